// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory arbiter FSM states and grant-owner encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    ERROR = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_SRC_I = 1'b0,
    GNT_SRC_D = 1'b1
  } gnt_src_t;

  localparam int ARB_CNT_W = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Datapath-side and RAM-side signal bundle of the memory arbiter.
interface mem_arbiter_if #(parameter int AW = 32);

  logic          iREN;
  logic [AW-1:0] iaddr;
  logic [AW-1:0] iload;
  logic          iwait;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [AW-1:0] dstore;
  logic [AW-1:0] dload;
  logic          dwait;
  logic          halt;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [AW-1:0] ramstore;
  logic [AW-1:0] ramload;
  logic          ram_ready;
  logic          err;

  // Environment side: datapath requests plus RAM responses.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ram_ready,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ram_ready,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between instruction fetch
// and data access, with a per-grant timeout that traps into a sticky error state.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam logic [ARB_CNT_W-1:0] TMO = ARB_CNT_W'(TIMEOUT);

  arb_state_t           state_q, state_d;
  gnt_src_t             last_gnt_q, last_gnt_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 dwr_q, dwr_d;

  logic dreq_s;
  logic ireq_s;
  logic done_i_s;
  logic done_d_s;

  assign dreq_s   = bus.dREN | bus.dWEN;
  assign ireq_s   = bus.iREN & ~bus.halt;
  assign done_i_s = (state_q == GNT_I) & bus.ram_ready;
  assign done_d_s = (state_q == GNT_D) & bus.ram_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_SRC_I;
      cnt_q      <= '0;
      dwr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      dwr_q      <= dwr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    dwr_d      = dwr_q;
    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time gets the RAM.
        if (dreq_s && (!ireq_s || (last_gnt_q == GNT_SRC_I))) begin
          state_d    = GNT_D;
          last_gnt_d = GNT_SRC_D;
          cnt_d      = '0;
          dwr_d      = bus.dWEN;
        end else if (ireq_s) begin
          state_d    = GNT_I;
          last_gnt_d = GNT_SRC_I;
          cnt_d      = '0;
          dwr_d      = 1'b0;
        end else begin
          state_d    = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (bus.ram_ready) begin
          state_d = IDLE;
        end else if ((cnt_q + 16'd1) >= TMO) begin
          state_d = ERROR;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM command follows the current owner; idle and error leave the bus quiet.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      GNT_I: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      GNT_D: begin
        bus.ramREN   = ~dwr_q;
        bus.ramWEN   = dwr_q;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: begin
        bus.ramREN   = 1'b0;
      end
    endcase
  end

  // A completion whose request has already dropped is discarded.
  assign bus.iwait = bus.iREN & ~done_i_s;
  assign bus.dwait = dreq_s & ~done_d_s;
  assign bus.iload = (done_i_s & bus.iREN) ? bus.ramload : {AW{1'b0}};
  assign bus.dload = (done_d_s & dreq_s)   ? bus.ramload : {AW{1'b0}};
  assign bus.err   = (state_q == ERROR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an ownership/age model predicts every output
// on each falling edge, and literal checks pin the key scenarios.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int TMO = 4;

  logic CLK = 1'b0;
  logic nRST;

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.TIMEOUT(TMO), .AW(AW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 fetch, 2 data, 3 trapped), how long it has waited.
  int own       = 0;
  int age       = 0;
  bit last_data = 1'b0;
  bit wr        = 1'b0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      own = 0; age = 0; last_data = 1'b0; wr = 1'b0;
    end else if (own == 0) begin
      bit dq, iq;
      dq = bus.dREN | bus.dWEN;
      iq = bus.iREN & ~bus.halt;
      if (dq && (!iq || !last_data)) begin
        own = 2; last_data = 1'b1; age = 0; wr = bus.dWEN;
      end else if (iq) begin
        own = 1; last_data = 1'b0; age = 0;
      end
    end else if (own == 1 || own == 2) begin
      if (bus.ram_ready) own = 0;
      else begin
        age++;
        if (age >= TMO) own = 3;
      end
    end
  end

  always @(negedge CLK) begin
    logic          dq, done_i, done_d;
    logic [AW-1:0] e_addr, e_store;
    dq      = bus.dREN | bus.dWEN;
    done_i  = (own == 1) && bus.ram_ready;
    done_d  = (own == 2) && bus.ram_ready;
    e_addr  = (own == 1) ? bus.iaddr : (own == 2) ? bus.daddr : 32'h0;
    e_store = (own == 2) ? bus.dstore : 32'h0;
    chk("cmp_ramREN",   32'(bus.ramREN),  32'((own == 1) || (own == 2 && !wr)));
    chk("cmp_ramWEN",   32'(bus.ramWEN),  32'(own == 2 && wr));
    chk("cmp_ramaddr",  bus.ramaddr,      e_addr);
    chk("cmp_ramstore", bus.ramstore,     e_store);
    chk("cmp_iwait",    32'(bus.iwait),   32'(bus.iREN && !done_i));
    chk("cmp_dwait",    32'(bus.dwait),   32'(dq && !done_d));
    chk("cmp_iload",    bus.iload,        (done_i && bus.iREN) ? bus.ramload : 32'h0);
    chk("cmp_dload",    bus.dload,        (done_d && dq) ? bus.ramload : 32'h0);
    chk("cmp_err",      32'(bus.err),     32'(own == 3));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = 32'h0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'h0; bus.dstore = 32'h0; bus.halt = 1'b0;
    bus.ramload = 32'h0; bus.ram_ready = 1'b0;
    cyc(); cyc();
    // Reset: waits mirror requests, bus quiet.
    bus.iREN = 1'b1; bus.dREN = 1'b1;
    neg();
    chk("rst_iwait", 32'(bus.iwait), 32'd1);
    chk("rst_dwait", 32'(bus.dwait), 32'd1);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    cyc();
    bus.iREN = 1'b0; bus.dREN = 1'b0; nRST = 1'b1;

    // Idle fetch, RAM ready immediately.
    cyc();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ram_ready = 1'b1; bus.ramload = 32'h8C010004;
    neg();
    chk("s1_c0_iwait", 32'(bus.iwait), 32'd1);
    chk("s1_c0_ramREN", 32'(bus.ramREN), 32'd0);
    cyc(); neg();
    chk("s1_ramREN", 32'(bus.ramREN), 32'd1);
    chk("s1_ramaddr", bus.ramaddr, 32'h40);
    chk("s1_iwait", 32'(bus.iwait), 32'd0);
    chk("s1_iload", bus.iload, 32'h8C010004);
    cyc();
    bus.iREN = 1'b0; bus.ram_ready = 1'b0;
    neg();
    chk("s1_bubble_ramREN", 32'(bus.ramREN), 32'd0);

    // Simultaneous requests after reset: data first, bubble, then fetch.
    cyc(); nRST = 1'b0;
    cyc(); nRST = 1'b1;
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h80;
    bus.ram_ready = 1'b1; bus.ramload = 32'h11;
    neg();
    chk("s2_c0_ramaddr", bus.ramaddr, 32'h0);
    cyc(); neg();
    chk("s2_c1_ramaddr", bus.ramaddr, 32'h80);
    chk("s2_c1_dload", bus.dload, 32'h11);
    chk("s2_c1_dwait", 32'(bus.dwait), 32'd0);
    chk("s2_c1_iwait", 32'(bus.iwait), 32'd1);
    cyc();
    bus.dREN = 1'b0;
    neg();
    chk("s2_c2_ramaddr", bus.ramaddr, 32'h0);
    cyc(); neg();
    chk("s2_c3_ramaddr", bus.ramaddr, 32'h44);
    chk("s2_c3_iload", bus.iload, 32'h11);
    cyc();
    bus.iREN = 1'b0; bus.ram_ready = 1'b0;

    // Write with 3-cycle RAM latency.
    cyc();
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    neg();
    chk("s3_c0_dwait", 32'(bus.dwait), 32'd1);
    chk("s3_c0_ramWEN", 32'(bus.ramWEN), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 3) begin
        bus.ram_ready = 1'b1; bus.ramload = 32'h55;
      end
      neg();
      chk("s3_ramWEN", 32'(bus.ramWEN), 32'd1);
      chk("s3_ramREN", 32'(bus.ramREN), 32'd0);
      chk("s3_ramstore", bus.ramstore, 32'hDEADBEEF);
      chk("s3_dwait", 32'(bus.dwait), (k < 3) ? 32'd1 : 32'd0);
      chk("s3_dload", bus.dload, (k == 3) ? 32'h55 : 32'h0);
    end
    cyc();
    bus.dWEN = 1'b0; bus.ram_ready = 1'b0;
    neg();
    chk("s3_end_ramWEN", 32'(bus.ramWEN), 32'd0);

    // Halt blocks a new fetch but not one already granted.
    cyc();
    bus.halt = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("s4_halt_ramREN", 32'(bus.ramREN), 32'd0);
      chk("s4_halt_iwait", 32'(bus.iwait), 32'd1);
      cyc();
    end
    bus.halt = 1'b0;
    cyc();
    bus.halt = 1'b1;
    neg();
    chk("s4_g1_ramREN", 32'(bus.ramREN), 32'd1);
    chk("s4_g1_ramaddr", bus.ramaddr, 32'h200);
    chk("s4_g1_iwait", 32'(bus.iwait), 32'd1);
    cyc();
    bus.ram_ready = 1'b1; bus.ramload = 32'h33;
    neg();
    chk("s4_g2_iload", bus.iload, 32'h33);
    chk("s4_g2_iwait", 32'(bus.iwait), 32'd0);
    cyc();
    bus.iREN = 1'b0; bus.halt = 1'b0; bus.ram_ready = 1'b0;
    neg();
    chk("s4_end_ramREN", 32'(bus.ramREN), 32'd0);

    // Reset asserted in the middle of a data grant.
    cyc();
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    neg();
    cyc(); neg();
    chk("s5_gnt_ramREN", 32'(bus.ramREN), 32'd1);
    chk("s5_gnt_ramaddr", bus.ramaddr, 32'h300);
    #2;
    nRST = 1'b0; bus.ram_ready = 1'b1; bus.ramload = 32'h77;
    #1;
    chk("s5_rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("s5_rst_ramaddr", bus.ramaddr, 32'h0);
    chk("s5_rst_dwait", 32'(bus.dwait), 32'd1);
    chk("s5_rst_dload", bus.dload, 32'h0);
    cyc();
    nRST = 1'b1; bus.dREN = 1'b0; bus.ram_ready = 1'b0;

    // Timeout after TMO grant cycles, error sticky until reset.
    cyc();
    bus.dREN = 1'b1; bus.daddr = 32'h400;
    neg();
    chk("s6_c0_err", 32'(bus.err), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); neg();
      chk("s6_err", 32'(bus.err), (k == 5) ? 32'd1 : 32'd0);
      chk("s6_ramREN", 32'(bus.ramREN), (k < 5) ? 32'd1 : 32'd0);
    end
    cyc();
    bus.dREN = 1'b0; bus.iREN = 1'b1; bus.ram_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("s6_sticky_err", 32'(bus.err), 32'd1);
      chk("s6_sticky_iwait", 32'(bus.iwait), 32'd1);
      chk("s6_sticky_ramREN", 32'(bus.ramREN), 32'd0);
      cyc();
    end
    nRST = 1'b0;
    neg();
    chk("s6_rst_err", 32'(bus.err), 32'd0);
    cyc();
    nRST = 1'b1; bus.iREN = 1'b0; bus.ram_ready = 1'b0;
    neg();
    chk("s6_post_err", 32'(bus.err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
